// File: rtl/fir_decim_sym.sv
// Symmetric complex decimating FIR: one pre-adder and one multiplier per rail, reloadable taps, runtime ratio.
// Define FIR_DECIM_SAT_EN to saturate the output to OBITS; otherwise the output wraps to its low OBITS bits.
module fir_decim_sym #(
    parameter int unsigned IBITS     = 18,
    parameter int unsigned CBITS     = 18,
    parameter int unsigned OBITS     = 24,
    parameter int unsigned TAPS      = 774,
    parameter int unsigned ADDRBITS  = 10,
    parameter int unsigned MAX_RATIO = 16,
    parameter int unsigned SHIFT     = 17,
    parameter int unsigned RBITS     = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [RBITS-1:0]           ratio,
    input  logic                       ratio_load,
    input  logic                       strobe_in,
    input  logic signed [IBITS-1:0]    x_real,
    input  logic signed [IBITS-1:0]    x_imag,
    input  logic                       coef_we,
    input  logic [ADDRBITS-2:0]        coef_addr,
    input  logic signed [CBITS-1:0]    coef_data,
    output logic                       strobe_out,
    output logic signed [OBITS-1:0]    y_real,
    output logic signed [OBITS-1:0]    y_imag,
    output logic                       busy,
    output logic                       overrun
);
    localparam int unsigned DEPTH = 2 ** ADDRBITS;
    localparam int unsigned NHALF = TAPS / 2;
    localparam int unsigned KBITS = ADDRBITS - 1;
    localparam int unsigned PBITS = IBITS + 1;
    localparam int unsigned MBITS = IBITS + CBITS + 1;
    localparam int unsigned ABITS = IBITS + CBITS + ADDRBITS;
    localparam int unsigned RSH   = (SHIFT == 0) ? 0 : SHIFT - 1;
    localparam logic signed [ABITS:0] RND = (SHIFT == 0) ? '0 : ((ABITS + 1)'(1) << RSH);
`ifdef FIR_DECIM_SAT_EN
    localparam logic signed [ABITS:0] OMAX = {{(ABITS + 2 - OBITS){1'b0}}, {(OBITS - 1){1'b1}}};
    localparam logic signed [ABITS:0] OMIN = ~OMAX;
`endif

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_MAC, S_DUMP} state_t;

    state_t                    r_state;
    logic                      r_busy, r_overrun, r_strobe_out, r_issue;
    logic [ADDRBITS-1:0]       r_clr, r_wptr, r_base;
    logic [RBITS-1:0]          r_ratio, r_phase;
    logic [KBITS-1:0]          r_k;
    logic signed [OBITS-1:0]   r_y_re, r_y_im;

    logic signed [IBITS-1:0]   r_buf_re [DEPTH];
    logic signed [IBITS-1:0]   r_buf_im [DEPTH];
    logic signed [CBITS-1:0]   r_coef   [NHALF];

    // pipeline: address, read, pre-add, multiply, accumulate
    logic                      r_a_vld, r_a_last, r_r_vld, r_r_last, r_p_vld, r_p_last, r_m_vld, r_m_last;
    logic [ADDRBITS-1:0]       r_a_lo, r_a_hi;
    logic [KBITS-1:0]          r_a_k;
    logic signed [IBITS-1:0]   r_rd_lo_re, r_rd_hi_re, r_rd_lo_im, r_rd_hi_im;
    logic signed [CBITS-1:0]   r_r_h, r_p_h;
    logic signed [PBITS-1:0]   r_pre_re, r_pre_im;
    logic signed [MBITS-1:0]   r_prod_re, r_prod_im;
    logic signed [ABITS-1:0]   r_acc_re, r_acc_im;

    logic                      w_clear, w_accept, w_adv, w_trig, w_k_last;
    logic [RBITS-1:0]          w_ratio_ld, w_ratio_eff, w_phase_eff, w_phase_nxt;
    logic                      w_buf_we;
    logic [ADDRBITS-1:0]       w_buf_addr;
    logic signed [IBITS-1:0]   w_wd_re, w_wd_im;

    function automatic logic signed [OBITS-1:0] f_narrow(input logic signed [ABITS-1:0] a);
        logic signed [ABITS:0] v;
        v = ((ABITS + 1)'(a) + RND) >>> SHIFT;
`ifdef FIR_DECIM_SAT_EN
        if (v > OMAX) begin
            v = OMAX;
        end else if (v < OMIN) begin
            v = OMIN;
        end
`endif
        return OBITS'(v);
    endfunction

    // a load in the same cycle as a sample takes effect first, so that sample is a trigger
    assign w_clear     = (r_state == S_CLEAR);
    assign w_accept    = strobe_in && !reset && !w_clear;
    assign w_adv       = !w_accept;
    assign w_ratio_ld  = (ratio == '0) ? RBITS'(1) :
                         (ratio > RBITS'(MAX_RATIO)) ? RBITS'(MAX_RATIO) : ratio;
    assign w_ratio_eff = ratio_load ? w_ratio_ld : r_ratio;
    assign w_phase_eff = ratio_load ? '0 : r_phase;
    assign w_phase_nxt = (w_phase_eff == w_ratio_eff - RBITS'(1)) ? '0 : w_phase_eff + RBITS'(1);
    assign w_trig      = w_accept && (w_phase_eff == '0);
    assign w_k_last    = (r_k == KBITS'(NHALF - 1));

    assign w_buf_we    = w_clear || w_accept;
    assign w_buf_addr  = w_clear ? r_clr : r_wptr;
    assign w_wd_re     = w_clear ? '0 : x_real;
    assign w_wd_im     = w_clear ? '0 : x_imag;

    always_ff @(posedge clock) begin
        if (w_buf_we) begin
            r_buf_re[w_buf_addr] <= w_wd_re;
            r_buf_im[w_buf_addr] <= w_wd_im;
        end
    end

    // coefficients survive reset and are only writable while idle
    always_ff @(posedge clock) begin
        if (coef_we && !r_busy && (32'(coef_addr) < NHALF)) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_CLEAR;
            r_busy       <= 1'b1;
            r_clr        <= '0;
            r_wptr       <= '0;
            r_phase      <= '0;
            r_ratio      <= RBITS'(1);
            r_overrun    <= 1'b0;
            r_strobe_out <= 1'b0;
            r_y_re       <= '0;
            r_y_im       <= '0;
            r_issue      <= 1'b0;
            r_a_vld      <= 1'b0;
            r_r_vld      <= 1'b0;
            r_p_vld      <= 1'b0;
            r_m_vld      <= 1'b0;
        end else begin
            r_strobe_out <= 1'b0;
            if (ratio_load) begin
                r_ratio <= w_ratio_ld;
            end
            if (w_accept) begin
                r_wptr  <= r_wptr - ADDRBITS'(1);
                r_phase <= w_phase_nxt;
            end else if (ratio_load) begin
                r_phase <= '0;
            end
            if (w_trig && (r_state == S_MAC || r_state == S_DUMP)) begin
                r_overrun <= 1'b1;
            end

            // the whole pipeline holds on cycles where the buffer port is taken by a write
            if (w_adv) begin
                r_a_vld  <= r_issue;
                r_a_last <= w_k_last;
                r_a_lo   <= r_base + ADDRBITS'(r_k);
                r_a_hi   <= r_base + ADDRBITS'(TAPS - 1) - ADDRBITS'(r_k);
                r_a_k    <= r_k;
                if (r_issue) begin
                    r_k <= r_k + KBITS'(1);
                    if (w_k_last) begin
                        r_issue <= 1'b0;
                    end
                end

                r_r_vld    <= r_a_vld;
                r_r_last   <= r_a_vld && r_a_last;
                r_rd_lo_re <= r_buf_re[r_a_lo];
                r_rd_hi_re <= r_buf_re[r_a_hi];
                r_rd_lo_im <= r_buf_im[r_a_lo];
                r_rd_hi_im <= r_buf_im[r_a_hi];
                r_r_h      <= r_coef[r_a_k];

                r_p_vld  <= r_r_vld;
                r_p_last <= r_r_last;
                r_pre_re <= PBITS'(r_rd_lo_re) + PBITS'(r_rd_hi_re);
                r_pre_im <= PBITS'(r_rd_lo_im) + PBITS'(r_rd_hi_im);
                r_p_h    <= r_r_h;

                r_m_vld   <= r_p_vld;
                r_m_last  <= r_p_last;
                r_prod_re <= MBITS'(r_pre_re) * MBITS'(r_p_h);
                r_prod_im <= MBITS'(r_pre_im) * MBITS'(r_p_h);

                if (r_m_vld) begin
                    r_acc_re <= r_acc_re + ABITS'(r_prod_re);
                    r_acc_im <= r_acc_im + ABITS'(r_prod_im);
                end
            end

            case (r_state)
                S_CLEAR: begin
                    r_clr <= r_clr + ADDRBITS'(1);
                    if (r_clr == '1) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (w_trig) begin
                        r_state  <= S_MAC;
                        r_busy   <= 1'b1;
                        r_base   <= r_wptr;
                        r_k      <= '0;
                        r_issue  <= 1'b1;
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                    end
                end
                S_MAC: begin
                    if (w_adv && r_m_vld && r_m_last) begin
                        r_state <= S_DUMP;
                    end
                end
                S_DUMP: begin
                    if (w_adv) begin
                        r_y_re       <= f_narrow(r_acc_re);
                        r_y_im       <= f_narrow(r_acc_im);
                        r_strobe_out <= 1'b1;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign strobe_out = r_strobe_out;
    assign y_real     = r_y_re;
    assign y_imag     = r_y_im;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_fir_decim_sym.sv
// Scoreboard bench for fir_decim_sym: a direct-form model predicts each decimated output at trigger time.
`timescale 1ns/1ps
module tb_fir_decim_sym;
    localparam int unsigned IBITS = 8, CBITS = 8, OBITS = 16, TAPS = 8, ADDRBITS = 4;
    localparam int unsigned MAX_RATIO = 16, SHIFT = 0, RBITS = 5;
    localparam int LAT = TAPS / 2 + 5;
    localparam int GAP = 12;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [RBITS-1:0]        ratio = '0;
    logic                    ratio_load = 1'b0;
    logic                    strobe_in = 1'b0;
    logic signed [IBITS-1:0] x_real = '0, x_imag = '0;
    logic                    coef_we = 1'b0;
    logic [ADDRBITS-2:0]     coef_addr = '0;
    logic signed [CBITS-1:0] coef_data = '0;
    logic                    strobe_out, busy, overrun;
    logic signed [OBITS-1:0] y_real, y_imag;

    fir_decim_sym #(.IBITS(IBITS), .CBITS(CBITS), .OBITS(OBITS), .TAPS(TAPS), .ADDRBITS(ADDRBITS),
                    .MAX_RATIO(MAX_RATIO), .SHIFT(SHIFT), .RBITS(RBITS)) dut (
        .clock(clock), .reset(reset), .ratio(ratio), .ratio_load(ratio_load), .strobe_in(strobe_in),
        .x_real(x_real), .x_imag(x_imag), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .strobe_out(strobe_out), .y_real(y_real), .y_imag(y_imag), .busy(busy), .overrun(overrun));

    always #5 clock = ~clock;

    typedef struct { int re; int im; int trig; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int n_vec = 0, n_err = 0, cyc = 0, n_out = 0, n_trig = 0;
    int hist_re[TAPS], hist_im[TAPS], h[TAPS/2];
    int m_ratio = 1, m_phase = 0;
    bit sb_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int narrow(input int a);
`ifdef FIR_DECIM_SAT_EN
        if (a > (1 << (OBITS - 1)) - 1) return (1 << (OBITS - 1)) - 1;
        if (a < -(1 << (OBITS - 1))) return -(1 << (OBITS - 1));
        return a;
`else
        logic signed [OBITS-1:0] t;
        t = OBITS'(a);
        return int'(t);
`endif
    endfunction

    always @(negedge clock) begin
        if (strobe_out) begin
            n_out++;
            if (sb_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe_out", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("y_real", int'(y_real), mon_e.re);
                    check("y_imag", int'(y_imag), mon_e.im);
                    check("latency", cyc - mon_e.trig, LAT);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // drives one sample; the model stores it and predicts the output when it is a trigger
    task automatic send(input int re, input int im, input bit ld, input int rv);
        int ar, ai;
        bit trig;
        if (ld) begin
            m_ratio = (rv == 0) ? 1 : ((rv > int'(MAX_RATIO)) ? int'(MAX_RATIO) : rv);
            m_phase = 0;
        end
        for (int i = TAPS - 1; i > 0; i--) begin
            hist_re[i] = hist_re[i-1];
            hist_im[i] = hist_im[i-1];
        end
        hist_re[0] = re;
        hist_im[0] = im;
        trig = (m_phase == 0);
        m_phase = (m_phase + 1 == m_ratio) ? 0 : m_phase + 1;
        if (trig) n_trig++;
        if (trig && sb_en) begin
            ar = 0;
            ai = 0;
            for (int k = 0; k < TAPS / 2; k++) begin
                ar += h[k] * (hist_re[k] + hist_re[TAPS-1-k]);
                ai += h[k] * (hist_im[k] + hist_im[TAPS-1-k]);
            end
            sb.push_back('{narrow(ar), narrow(ai), cyc + 1});
        end
        x_real = IBITS'(re);
        x_imag = IBITS'(im);
        ratio = RBITS'(rv);
        ratio_load = ld;
        strobe_in = 1'b1;
        tick(1);
        strobe_in = 1'b0;
        ratio_load = 1'b0;
    endtask

    task automatic send_gap(input int re, input int im, input bit ld, input int rv);
        send(re, im, ld, rv);
        tick(GAP - 1);
    endtask

    task automatic load_coef(input int k, input int v, input bit taken);
        coef_we = 1'b1;
        coef_addr = (ADDRBITS-1)'(k);
        coef_data = CBITS'(v);
        tick(1);
        coef_we = 1'b0;
        if (taken) h[k] = v;
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while ((busy || sb.size() != 0) && i < 400) begin
            tick(1);
            i++;
        end
        check(tag, int'(i < 400), 1);
    endtask

    // reset, then check CLEAR length while poking strobe_in, which must be ignored
    task automatic do_reset();
        int nb = 0, k = 0;
        reset = 1'b1;
        strobe_in = 1'b0;
        tick(3);
        check("rst_strobe_out", int'(strobe_out), 0);
        check("rst_y_real", int'(y_real), 0);
        check("rst_y_imag", int'(y_imag), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_busy", int'(busy), 1);
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < TAPS; i++) begin
            hist_re[i] = 0;
            hist_im[i] = 0;
        end
        m_ratio = 1;
        m_phase = 0;
        while (busy && k < 40) begin
            nb++;
            strobe_in = (k == 5 || k == 15);
            x_real = 55;
            x_imag = 55;
            tick(1);
            k++;
        end
        strobe_in = 1'b0;
        check("clear_cycles", nb, 1 << ADDRBITS);
        check("clear_overrun", int'(overrun), 0);
        check("clear_strobe_out", int'(strobe_out), 0);
    endtask

    initial begin
        int o0;
        do_reset();
        for (int k = 0; k < TAPS / 2; k++) load_coef(k, k + 1, 1'b1);
        sb_en = 1'b1;

        // impulse at ratio 1, then at ratio 2 with the load coincident with the first sample
        send_gap(100, 0, 1'b0, 0);
        for (int i = 0; i < TAPS; i++) send_gap(0, 0, 1'b0, 0);
        drain("drain_imp1");
        send_gap(100, 0, 1'b1, 2);
        for (int i = 0; i < TAPS; i++) send_gap(0, 0, 1'b0, 0);
        drain("drain_imp2");

        // ratio 0 clamps to 1; complex and random patterns
        ratio = '0;
        ratio_load = 1'b1;
        m_ratio = 1;
        m_phase = 0;
        tick(1);
        ratio_load = 1'b0;
        send_gap(-50, 30, 1'b0, 0);
        for (int i = 0; i < TAPS - 1; i++) send_gap(0, 0, 1'b0, 0);
        for (int i = 0; i < TAPS; i++)
            send_gap(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, 1'b0, 0);
        drain("drain_rand");

        // coefficient write during MAC is dropped
        for (int i = 0; i < TAPS; i++) send_gap(0, 0, 1'b0, 0);
        send(100, 0, 1'b0, 0);
        check("busy_in_mac", int'(busy), 1);
        load_coef(0, 0, 1'b0);
        tick(GAP - 2);
        for (int i = 0; i < TAPS; i++) send_gap(0, 0, 1'b0, 0);
        drain("drain_coefbusy");

        // DC at full scale: saturates or wraps depending on the build
        for (int k = 0; k < TAPS / 2; k++) load_coef(k, 127, 1'b1);
        for (int i = 0; i < TAPS + 1; i++) send_gap(127, -127, 1'b0, 0);
        drain("drain_dc");

        // overrun with samples every other cycle
        sb_en = 1'b0;
        o0 = n_out;
        n_trig = 0;
        send(1, 1, 1'b0, 0);
        tick(1);
        check("overrun_before", int'(overrun), 0);
        send(2, 2, 1'b0, 0);
        check("overrun_set", int'(overrun), 1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            send(i, -i, 1'b0, 0);
        end
        drain("drain_overrun");
        check("out_lt_trig", int'((n_out - o0) < n_trig), 1);
        tick(20);
        check("overrun_sticky", int'(overrun), 1);

        // reset mid-MAC aborts without an output
        o0 = n_out;
        send(100, 0, 1'b0, 0);
        tick(3);
        do_reset();
        check("abort_no_out", n_out - o0, 0);

        // coefficients retained across reset and ratio back to 1
        sb_en = 1'b1;
        send_gap(100, 0, 1'b0, 0);
        for (int i = 0; i < TAPS; i++) send_gap(0, 0, 1'b0, 0);
        drain("drain_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
